// File: rtl/tactile_pkg.sv
// tactile_pkg: shared types, constants and helpers for the tactile heatmap lookup.
//   scale_t      - zoom selection (1, 16, 32 or 64 screen pixels per cell)
//   scale_shift  - coordinate shift amount for a zoom selection
//   CELL_CNT     - number of cells in one frame for the default 16x16 wire grid
//   CELL_AW      - address width of one frame bank for the default grid
//   heat_rgb444  - maps a normalised 5-bit sample to an RGB444 heat colour
package tactile_pkg;

    localparam int SW_WIRE_CNT_DEF = 16;
    localparam int RD_WIRE_CNT_DEF = 16;
    localparam int CELL_CNT        = SW_WIRE_CNT_DEF * RD_WIRE_CNT_DEF;
    localparam int CELL_AW         = $clog2(CELL_CNT);

    typedef enum logic [1:0] {
        SCALE_1  = 2'b00,
        SCALE_16 = 2'b01,
        SCALE_32 = 2'b10,
        SCALE_64 = 2'b11
    } scale_t;

    function automatic logic [2:0] scale_shift(input scale_t scale);
        logic [2:0] sh;
        case (scale)
            SCALE_1:  sh = 3'd0;
            SCALE_16: sh = 3'd4;
            SCALE_32: sh = 3'd5;
            default:  sh = 3'd6;
        endcase
        return sh;
    endfunction

    // s[4] selects the cold (blue->green) or hot (green->red) ramp,
    // s[3:0] is the position along that ramp.
    function automatic logic [11:0] heat_rgb444(input logic [4:0] s);
        logic [3:0] t;
        t = s[3:0];
        if (s[4])
            return {t, 4'hF - t, 4'h0};
        else
            return {4'h0, t, 4'hF - t};
    endfunction

endpackage

// File: rtl/tactile_frame_ram.sv
// tactile_frame_ram: simple dual-port RAM holding both tactile frame banks.
//   clk_in  - clock
//   rst_in  - synchronous active-high reset, clears only the read register
//   we_in / waddr_in / wdata_in - write port
//   raddr_in / rdata_out        - registered read port (one cycle latency)
// The bank select is the address MSB, supplied by the caller.
module tactile_frame_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [ADDR_W-1:0] raddr_in,
    output logic [DATA_W-1:0] rdata_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we_in)
            mem[waddr_in] <= wdata_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            rdata_out <= '0;
        else
            rdata_out <= mem[raddr_in];
    end

endmodule

// File: rtl/tactile_pixel_lookup.sv
// tactile_pixel_lookup: converts raster coordinates into an RGB444 heatmap
// pixel taken from a double-buffered tactile frame store.
//   clk_in, rst_in       - clock, synchronous active-high reset
//   scale_in             - zoom select, latched at frame start
//   hcount_in/vcount_in  - raster coordinates
//   wr_valid_in/wr_addr_in/wr_data_in - sample writes into the inactive bank
//   wr_frame_done_in     - inactive bank holds a complete frame; swap at next frame start
//   hcount_out/vcount_out/data_out - coordinates and pixel, 3 cycles after input
//   active_bank_out      - bank currently being displayed
module tactile_pixel_lookup
    import tactile_pkg::*;
#(
    parameter int SW_WIRE_CNT  = 16,
    parameter int RD_WIRE_CNT  = 16,
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic [1:0]                                  scale_in,
    input  logic [10:0]                                 hcount_in,
    input  logic [9:0]                                  vcount_in,
    input  logic                                        wr_valid_in,
    input  logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0]  wr_addr_in,
    input  logic [SAMPLE_WIDTH-1:0]                     wr_data_in,
    input  logic                                        wr_frame_done_in,
    output logic [10:0]                                 hcount_out,
    output logic [9:0]                                  vcount_out,
    output logic [11:0]                                 data_out,
    output logic                                        active_bank_out
);

    localparam int CELLS  = SW_WIRE_CNT * RD_WIRE_CNT;
    localparam int ADDR_W = $clog2(CELLS);

    // Control state
    scale_t scale_q;
    logic   active_bank;
    logic   pending;

    // Frame-start handling is combinational so the frame-start pixel already
    // sees the new scale and the swapped bank.
    logic        frame_start;
    logic        swap;
    scale_t      scale_cur;
    logic        bank_cur;
    logic [2:0]  shift;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        oor_c;
    logic [ADDR_W-1:0] addr_c;

    always_comb begin
        frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
        swap        = frame_start && pending;
        scale_cur   = frame_start ? scale_t'(scale_in) : scale_q;
        bank_cur    = swap ? ~active_bank : active_bank;
        shift       = scale_shift(scale_cur);
        cx          = hcount_in >> shift;
        cy          = vcount_in >> shift;
        oor_c       = (32'(cx) >= 32'(SW_WIRE_CNT)) || (32'(cy) >= 32'(RD_WIRE_CNT));
        addr_c      = oor_c ? '0 : ADDR_W'(32'(cy) * 32'(SW_WIRE_CNT) + 32'(cx));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            scale_q     <= SCALE_1;
            active_bank <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (frame_start)
                scale_q <= scale_cur;
            if (swap)
                active_bank <= ~active_bank;
            // A done pulse wins over the clear, so a done coinciding with a
            // frame start defers its swap to the following frame.
            if (wr_frame_done_in)
                pending <= 1'b1;
            else if (swap)
                pending <= 1'b0;
        end
    end

    assign active_bank_out = active_bank;

    // Writes always land in the bank that is inactive before any swap this cycle.
    logic              we;
    logic [ADDR_W:0]   waddr;
    assign we    = wr_valid_in && !rst_in && (32'(wr_addr_in) < 32'(CELLS));
    assign waddr = {~active_bank, wr_addr_in};

    // Stage 1: cell address
    logic [ADDR_W-1:0] addr_p1;
    logic              bank_p1;
    logic              oor_p1;
    logic [10:0]       hcount_p1;
    logic [9:0]        vcount_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_p1   <= '0;
            bank_p1   <= 1'b0;
            oor_p1    <= 1'b0;
            hcount_p1 <= '0;
            vcount_p1 <= '0;
        end else begin
            addr_p1   <= addr_c;
            bank_p1   <= bank_cur;
            oor_p1    <= oor_c;
            hcount_p1 <= hcount_in;
            vcount_p1 <= vcount_in;
        end
    end

    // Stage 2: frame store read
    logic [SAMPLE_WIDTH-1:0] sample_p2;
    logic                    oor_p2;
    logic [10:0]             hcount_p2;
    logic [9:0]              vcount_p2;

    tactile_frame_ram #(
        .DATA_W (SAMPLE_WIDTH),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .we_in     (we),
        .waddr_in  (waddr),
        .wdata_in  (wr_data_in),
        .raddr_in  ({bank_p1, addr_p1}),
        .rdata_out (sample_p2)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            oor_p2    <= 1'b0;
            hcount_p2 <= '0;
            vcount_p2 <= '0;
        end else begin
            oor_p2    <= oor_p1;
            hcount_p2 <= hcount_p1;
            vcount_p2 <= vcount_p1;
        end
    end

    // Stage 3: colour map. The sample is reduced to its top five bits
    // (ramp select + 4-bit ramp position).
    logic [4:0]  sample5;
    logic [11:0] pix_c;

    always_comb begin
        sample5 = 5'(sample_p2 >> (SAMPLE_WIDTH - 5));
        pix_c   = oor_p2 ? 12'h000 : heat_rgb444(sample5);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out   <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            data_out   <= pix_c;
            hcount_out <= hcount_p2;
            vcount_out <= vcount_p2;
        end
    end

endmodule
